// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump transmitter.
package regdump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    IDX  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_e;

  localparam int NUM_REGS      = 15;
  localparam int BYTES_PER_REG = 8;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [3:0] LAST_REG      = 4'(NUM_REGS - 1);
  localparam logic [2:0] LAST_BYTE     = 3'(BYTES_PER_REG - 1);

endpackage

// File: rtl/regdump_bytesel.sv
// Picks one byte of a 64-bit register word, byte 0 being the LSB.
module regdump_bytesel (
  input  logic [63:0] word,
  input  logic [2:0]  sel,
  output logic [7:0]  data
);

  assign data = word[{sel, 3'b000} +: 8];

endmodule

// File: rtl/regdump_tx.sv
// Serialises a snapshot of the 15 Y86-64 registers as a framed byte stream.
// Define REGDUMP_CSUM_EN to append an XOR checksum byte to each frame.
module regdump_tx
  import regdump_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] rax,
  input  logic [63:0] rcx,
  input  logic [63:0] rdx,
  input  logic [63:0] rbx,
  input  logic [63:0] rsp,
  input  logic [63:0] rbp,
  input  logic [63:0] rsi,
  input  logic [63:0] rdi,
  input  logic [63:0] r8,
  input  logic [63:0] r9,
  input  logic [63:0] r10,
  input  logic [63:0] r11,
  input  logic [63:0] r12,
  input  logic [63:0] r13,
  input  logic [63:0] r14,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  state_e      state;
  logic [3:0]  reg_cnt;
  logic [2:0]  byte_cnt;
  logic [63:0] snap [NUM_REGS];
  logic [63:0] regs [NUM_REGS];

  logic        hs;
  logic        last_byte;
  logic        last_reg;
  logic [2:0]  sel;
  logic [7:0]  sel_byte;

`ifdef REGDUMP_CSUM_EN
  logic [7:0]  csum;
`endif

  assign regs[0]  = rax;
  assign regs[1]  = rcx;
  assign regs[2]  = rdx;
  assign regs[3]  = rbx;
  assign regs[4]  = rsp;
  assign regs[5]  = rbp;
  assign regs[6]  = rsi;
  assign regs[7]  = rdi;
  assign regs[8]  = r8;
  assign regs[9]  = r9;
  assign regs[10] = r10;
  assign regs[11] = r11;
  assign regs[12] = r12;
  assign regs[13] = r13;
  assign regs[14] = r14;

  assign hs        = tx_valid && tx_ready;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_reg  = (reg_cnt == LAST_REG);

  // Look one byte ahead: IDX preloads byte 0, DATA preloads byte_cnt+1.
  assign sel = (state == DATA) ? byte_cnt + 3'd1 : 3'd0;

  regdump_bytesel u_bytesel (
    .word (snap[reg_cnt]),
    .sel  (sel),
    .data (sel_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reg_cnt  <= 4'd0;
      byte_cnt <= 3'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        snap[i] <= 64'd0;
`ifdef REGDUMP_CSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++)
              snap[i] <= regs[i];
            state    <= SYNC;
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SYNC: begin
          if (hs) begin
            state   <= IDX;
            reg_cnt <= 4'd0;
            tx_data <= 8'h00;
`ifdef REGDUMP_CSUM_EN
            csum    <= 8'h00;
`endif
          end
        end
        IDX: begin
          if (hs) begin
            state    <= DATA;
            byte_cnt <= 3'd0;
            tx_data  <= sel_byte;
`ifdef REGDUMP_CSUM_EN
            csum     <= csum ^ tx_data;
`endif
          end
        end
        DATA: begin
          if (hs) begin
            byte_cnt <= byte_cnt + 3'd1;
`ifdef REGDUMP_CSUM_EN
            csum     <= csum ^ tx_data;
`endif
            if (!last_byte) begin
              tx_data <= sel_byte;
            end else if (!last_reg) begin
              state   <= IDX;
              reg_cnt <= reg_cnt + 4'd1;
              tx_data <= {4'h0, reg_cnt + 4'd1};
            end else begin
`ifdef REGDUMP_CSUM_EN
              state   <= CSUM;
              tx_data <= csum ^ tx_data;
`else
              state    <= IDLE;
              reg_cnt  <= 4'd0;
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
`endif
            end
          end
        end
`ifdef REGDUMP_CSUM_EN
        CSUM: begin
          if (hs) begin
            state    <= IDLE;
            reg_cnt  <= 4'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regdump_tx.sv
// Scoreboard bench for regdump_tx: a frame model feeds a byte queue.
// A monitor pops and compares on each handshake and checks stall stability.
module tb_regdump_tx;

`ifdef REGDUMP_CSUM_EN
  localparam int FLEN = 137;
`else
  localparam int FLEN = 136;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b1;
  logic [63:0] regs [15];
  logic [63:0] model_regs [15];
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [7:0]  exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          byte_idx = 0;
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [7:0]  last_acc = 8'h00;

  regdump_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rax      (regs[0]),
    .rcx      (regs[1]),
    .rdx      (regs[2]),
    .rbx      (regs[3]),
    .rsp      (regs[4]),
    .rbp      (regs[5]),
    .rsi      (regs[6]),
    .rdi      (regs[7]),
    .r8       (regs[8]),
    .r9       (regs[9]),
    .r10      (regs[10]),
    .r11      (regs[11]),
    .r12      (regs[12]),
    .r13      (regs[13]),
    .r14      (regs[14]),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: sync, then per register an index and 8 LSB-first bytes.
  task automatic push_frame();
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int n = 0; n < 15; n++) begin
      b = 8'(n);
      exp_q.push_back(b);
      c = c ^ b;
      for (int k = 0; k < 8; k++) begin
        b = 8'(model_regs[n] >> (8 * k));
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
`ifdef REGDUMP_CSUM_EN
    exp_q.push_back(c);
`endif
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < 15; i++)
      model_regs[i] = regs[i];
  endtask

  task automatic issue_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    byte_idx = 0;
    take_snapshot();
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: got no done expected done within %0d", budget);
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (byte_idx < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_byte", 64'(byte_idx >= n), 64'd1);
  endtask

  initial begin
    logic       stall_prev;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall_prev = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev && tx_valid)
          check("stall_hold", tx_data, stall_data);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_byte: got %0h expected no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d", byte_idx), tx_data, e);
          end
          last_acc = tx_data;
          byte_idx++;
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (done) done_cnt++;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gap;
    for (int i = 0; i < 15; i++) regs[i] = 64'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'h00);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Known pattern, sink always ready
    regs[0] = 64'h0123456789ABCDEF;
    issue_start();
    check("lat_valid", 64'(tx_valid), 64'd1);
    check("lat_data", 64'(tx_data), 64'hA5);
    check("lat_busy", 64'(busy), 64'd1);
    wait_done(400, cyc);
    check("frame_cycles", 64'(cyc), 64'(FLEN));
    check("end_valid", 64'(tx_valid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("done_width", 64'(done), 64'd0);
`ifdef REGDUMP_CSUM_EN
    check("csum_byte", 64'(last_acc), 64'h0F);
`else
    check("last_byte", 64'(last_acc), 64'h00);
`endif
    check("q_empty1", 64'(exp_q.size()), 64'd0);

    // All ones with random back-pressure
    for (int i = 0; i < 15; i++) regs[i] = '1;
    rand_ready = 1'b1;
    issue_start();
    wait_done(3000, cyc);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    check("q_empty2", 64'(exp_q.size()), 64'd0);

    // Register change after snapshot must not leak into the frame
    for (int i = 0; i < 15; i++) regs[i] = 64'd0;
    regs[3] = 64'h11;
    issue_start();
    @(posedge clk);
    #1;
    regs[3] = 64'h22;
    wait_done(400, cyc);
    @(posedge clk);
    #1;
    check("q_empty3", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored
    for (int i = 0; i < 15; i++) regs[i] = {$urandom, $urandom};
    done_cnt = 0;
    issue_start();
    wait_bytes(40);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, cyc);
    repeat (5) @(posedge clk);
    #1;
    check("one_done", 64'(done_cnt), 64'd1);
    check("idle_valid", 64'(tx_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("q_empty4", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame
    for (int i = 0; i < 15; i++) regs[i] = {$urandom, $urandom};
    issue_start();
    wait_bytes(70);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(tx_valid), 64'd0);
    check("mrst_data", 64'(tx_data), 64'h00);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(tx_valid), 64'd0);
    issue_start();
    check("restart_data", 64'(tx_data), 64'hA5);
    wait_done(400, cyc);
    check("restart_cycles", 64'(cyc), 64'(FLEN));

    // Start held high: back-to-back frames
    for (int i = 0; i < 15; i++) regs[i] = {$urandom, $urandom};
    @(posedge clk);
    #1;
    start = 1'b1;
    byte_idx = 0;
    take_snapshot();
    push_frame();
    push_frame();
    wait_done(400, cyc);
    gap = 0;
    while (gap < 10) begin
      @(posedge clk);
      #1;
      gap++;
      if (tx_valid) break;
    end
    check("b2b_gap", 64'(gap), 64'd1);
    check("b2b_sync", 64'(tx_data), 64'hA5);
    wait_done(400, cyc);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_stop", 64'(tx_valid), 64'd0);
    check("q_empty6", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regdump_tx.md
# regdump_tx

Register-file dump transmitter for the Y86-64 core. It reads the fifteen architectural register outputs of the register file and, on request, serialises them as a framed byte stream over a valid/ready interface. The block sits beside the register file and feeds a host-side UART or debug FIFO, so test programs can be checked after `halt` without probing waveforms. The register file is the writer; this block is its reader.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: asynchronous reset, active-low.
- `start` input 1: dump request, level-sampled; acted on only in IDLE.
- `rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8 … r14` input 64 each: register-file outputs, indices 0..14 in that order.
- `tx_data` output 8: current stream byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: sink accepts the byte on a cycle with `tx_valid && tx_ready`.
- `busy` output 1: high from start acceptance until the final byte is accepted.
- `done` output 1: one-cycle pulse after the final handshake.

## Operation
- Frame layout: SYNC_BYTE, then for each register n = 0..14, an index byte {4'h0, n} followed by 8 data bytes, least significant first. Optional checksum byte at the end. Base length is 136 bytes.
- On the cycle `start` is sampled in IDLE, all 15 registers are snapshotted into an internal array. Register changes after that point do not affect the frame.
- States:
  - IDLE → SYNC on `start`.
  - SYNC → IDX on handshake.
  - IDX → DATA on handshake.
  - DATA → DATA until byte_cnt = 7. On the handshake with byte_cnt = 7, go to IDX if reg_cnt < 14, otherwise to CSUM (macro defined) or IDLE.
  - CSUM → IDLE on handshake.
- Counters:
  - reg_cnt is 4 bits, range 0..14. It clears in SYNC and increments on the last DATA handshake of each register.
  - byte_cnt is 3 bits. It clears on entry to DATA and wraps 7 → 0.
- A state advances only on a handshake. Holding `tx_ready` low stalls the FSM indefinitely.
- `start` while busy is ignored: no restart and no queueing.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0, state IDLE, counters 0, snapshot 0.
- Latency: `start` sampled high at edge k gives `tx_valid`=1 with `tx_data`=SYNC_BYTE and `busy`=1 after edge k.
- Stream rules:
  - `tx_valid` is continuous for the whole frame, with no bubbles.
  - The next byte appears on the edge of each handshake.
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - `tx_valid` never depends combinationally on `tx_ready`.
- Completion: on the final handshake, `tx_valid` and `busy` drop and `done` pulses for exactly one cycle, all on the same edge.
- If `start` is high on the cycle after `done`, a new frame begins. Back-to-back frames have a minimum gap of one IDLE cycle.
- Reset mid-frame: all outputs return to their reset values asynchronously. The partial frame is abandoned, with no `done`.
- Peak throughput: one byte per cycle with `tx_ready` tied high. A frame is 136 cycles, or 137 with the checksum.

## Configuration
- `REGDUMP_CSUM_EN` defined:
  - An 8-bit running XOR covers every index and data byte; SYNC_BYTE is excluded.
  - The XOR clears in SYNC and is sent as byte 137 from state CSUM.
- Undefined: no CSUM state, no checksum register, and the frame is 136 bytes.

## Structure
- Package `regdump_pkg`:
  - State enum {IDLE, SYNC, IDX, DATA, CSUM}.
  - `NUM_REGS` = 15, `BYTES_PER_REG` = 8.
  - Default `SYNC_BYTE` constant.
- One sub-module, `regdump_bytesel`: combinational 64-bit to byte selector indexed by byte_cnt. Everything else stays in the top.

## Test plan
- Reset, then `rax`=64'h0123456789ABCDEF, others 0, `tx_ready`=1, pulse `start`:
  - Stream is A5,00,EF,CD,AB,89,67,45,23,01,01,00×8,02,…,0E,00×8.
  - `done` arrives 136 cycles after the first `tx_valid`.
  - With `REGDUMP_CSUM_EN`, the 137th byte is 8'h0F.
- Random `tx_ready` gaps, all registers = 64'hFFFF_FFFF_FFFF_FFFF:
  - Identical byte sequence to the unstalled run.
  - `tx_data` stable across every stall cycle.
- Change `rbx` from 64'h11 to 64'h22 two cycles after `start`: frame carries 11,00×7 for index 03.
- Pulse `start` at byte 40 of a frame: ignored; the frame completes normally with exactly one `done`.
- Assert `rst_n` low at byte 70: outputs are reset values the same cycle. A later `start` produces a full frame beginning with A5.
- Hold `start` high continuously: back-to-back frames with exactly one IDLE cycle between `done` and the next A5.
